// File: rtl/mold_pkg.sv
// Shared widths, header layout and parser state for the MoldUDP64 splitter.
package mold_pkg;

  localparam int DATA_W = 64;
  localparam int KEEP_W = DATA_W / 8;
  localparam int LEN_W  = 16;

  // Header layout in bytes: session id, sequence number, message count.
  localparam logic [4:0] SID_LEN = 5'd10;
  localparam logic [4:0] SEQ_LEN = 5'd8;
  localparam logic [4:0] CNT_LEN = 5'd2;
  localparam logic [4:0] CNT_OFF = SID_LEN + SEQ_LEN;
  localparam logic [4:0] HDR_LEN = CNT_OFF + CNT_LEN;

  typedef enum logic [1:0] {
    ST_HDR     = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DRAIN   = 2'd3
  } state_e;

  // Complete parser context; the state field doubles as the FSM debug view.
  typedef struct packed {
    state_e           state;
    logic [4:0]       hdr_cnt;   // header bytes seen so far
    logic             len_half;  // low byte of a length field already taken
    logic [7:0]       len_lo;    // that low byte
    logic [LEN_W-1:0] msg_left;  // messages still to finish in this packet
    logic [LEN_W-1:0] cur_len;   // L of the message being emitted
    logic [LEN_W-1:0] rem;       // payload bytes still owed for it
    logic             first;     // next payload byte opens the message
  } parse_t;

endpackage

// File: rtl/mold_len_cnt.sv
// Walks the lanes of one beat from start_lane_i upward, advancing the parser
// context byte by byte and collecting the lanes of a single payload segment.
// When a second message's payload would begin inside the same beat, the walk
// stops there and reports the lane so the beat can be re-presented.
module mold_len_cnt
  import mold_pkg::*;
(
  input  parse_t              cur_i,
  input  logic [2:0]          start_lane_i,
  input  logic [KEEP_W-1:0]   tkeep_i,
  input  logic [DATA_W-1:0]   tdata_i,
  output parse_t              nxt_o,
  output logic [KEEP_W-1:0]   mask_o,
  output logic                start_o,
  output logic [LEN_W-1:0]    len_o,
  output logic                split_o,
  output logic [2:0]          split_lane_o
);

  parse_t            p;
  logic [KEEP_W-1:0] mask;
  logic              sstart;
  logic [LEN_W-1:0]  slen;
  logic              split;
  logic [2:0]        slane;
  logic              stop;
  logic [7:0]        b;

  // Byte-serial parse of every kept lane at or above the resume lane.
  always_comb begin
    p      = cur_i;
    mask   = '0;
    sstart = 1'b0;
    slen   = '0;
    split  = 1'b0;
    slane  = 3'd0;
    stop   = 1'b0;
    b      = 8'h00;
    for (int k = 0; k < KEEP_W; k++) begin
      b = tdata_i[8*k +: 8];
      if (!stop && (k >= int'(start_lane_i)) && tkeep_i[k]) begin
        case (p.state)
          ST_HDR: begin
            if (p.hdr_cnt == CNT_OFF)         p.msg_left[7:0]  = b;
            if (p.hdr_cnt == CNT_OFF + 5'd1)  p.msg_left[15:8] = b;
            if (p.hdr_cnt == HDR_LEN - 5'd1) begin
              p.len_half = 1'b0;
              p.state    = (p.msg_left != '0) ? ST_LEN : ST_DRAIN;
            end
            p.hdr_cnt = p.hdr_cnt + 5'd1;
          end
          ST_LEN: begin
            if (!p.len_half) begin
              p.len_lo   = b;
              p.len_half = 1'b1;
            end else begin
              p.len_half = 1'b0;
              if ({b, p.len_lo} == '0) begin
                // Empty message: counts as done, nothing to emit.
                p.msg_left = p.msg_left - 16'd1;
                if (p.msg_left == '0) p.state = ST_DRAIN;
              end else begin
                p.cur_len = {b, p.len_lo};
                p.rem     = {b, p.len_lo};
                p.first   = 1'b1;
                p.state   = ST_PAYLOAD;
              end
            end
          end
          ST_PAYLOAD: begin
            if (p.first && (mask != '0)) begin
              stop  = 1'b1;
              split = 1'b1;
              slane = 3'(k);
            end else begin
              mask[k] = 1'b1;
              if (p.first) sstart = 1'b1;
              p.first = 1'b0;
              slen    = p.cur_len;
              p.rem   = p.rem - 16'd1;
              if (p.rem == '0) begin
                p.msg_left = p.msg_left - 16'd1;
                p.len_half = 1'b0;
                p.state    = (p.msg_left == '0) ? ST_DRAIN : ST_LEN;
              end
            end
          end
          default: ;
        endcase
      end
    end
    nxt_o        = p;
    mask_o       = mask;
    start_o      = sstart;
    len_o        = slen;
    split_o      = split;
    split_lane_o = slane;
  end

endmodule

// File: rtl/top.sv
// MoldUDP64 message splitter: parses the UDP payload stream and emits message
// payload beats with a lane mask, one message segment per cycle.
// Handshake: a beat transfers on a cycle where tvalid and tready are both 1.
// tready is 0 during reset and on cycles where the presented beat still holds
// another message's payload segment; the source must hold the beat stable.
module top
  import mold_pkg::*;
#(
  parameter int AXI_DATA_W = 64,
  parameter int AXI_KEEP_W = AXI_DATA_W / 8,
  parameter int ML_W       = 16
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  upd_axis_tvalid_i,
  input  logic [AXI_KEEP_W-1:0] upd_axis_tkeep_i,
  input  logic [AXI_DATA_W-1:0] upd_axis_tdata_i,
  input  logic                  upd_axis_tlast_i,
  input  logic                  upd_axis_tuser_i,
  output logic                  upd_axis_tready_o,
  output logic                  mold_msg_v_o,
  output logic                  mold_msg_start_o,
  output logic [ML_W-1:0]       mold_msg_len_o,
  output logic [AXI_KEEP_W-1:0] mold_msg_mask_o,
  output logic [AXI_DATA_W-1:0] mold_msg_data_o
);

  parse_t ps_q, ps_d, walk_nxt;
  logic [2:0] pos_q, pos_d;

  logic                  v_q, v_d;
  logic                  start_q, start_d;
  logic [ML_W-1:0]       len_q, len_d;
  logic [AXI_KEEP_W-1:0] mask_q, mask_d;
  logic [AXI_DATA_W-1:0] data_q, data_d;

  logic [KEEP_W-1:0] walk_mask;
  logic              walk_start;
  logic [LEN_W-1:0]  walk_len;
  logic              walk_split;
  logic [2:0]        walk_lane;
  logic              proc;
  logic              stall;

  mold_len_cnt u_len_cnt (
    .cur_i        (ps_q),
    .start_lane_i (pos_q),
    .tkeep_i      (upd_axis_tkeep_i),
    .tdata_i      (upd_axis_tdata_i),
    .nxt_o        (walk_nxt),
    .mask_o       (walk_mask),
    .start_o      (walk_start),
    .len_o        (walk_len),
    .split_o      (walk_split),
    .split_lane_o (walk_lane)
  );

  // An errored beat is never split: it is taken whole and dropped.
  assign proc  = upd_axis_tvalid_i && !nreset;
  assign stall = proc && !upd_axis_tuser_i && walk_split;
  assign upd_axis_tready_o = !nreset && !stall;

  // Next parser context and next registered output for the presented beat.
  always_comb begin
    ps_d    = ps_q;
    pos_d   = pos_q;
    v_d     = 1'b0;
    start_d = 1'b0;
    len_d   = '0;
    mask_d  = '0;
    data_d  = '0;
    if (proc) begin
      if (upd_axis_tuser_i) begin
        ps_d.state = ST_DRAIN;
        pos_d      = 3'd0;
      end else begin
        ps_d  = walk_nxt;
        pos_d = walk_split ? walk_lane : 3'd0;
        if (walk_mask != '0) begin
          v_d     = 1'b1;
          start_d = walk_start;
          len_d   = walk_len;
          mask_d  = walk_mask;
          data_d  = upd_axis_tdata_i;
        end
      end
      // Packet end: whatever was in progress, the next beat is header beat 0.
      if (upd_axis_tlast_i && !stall) begin
        ps_d  = '0;
        pos_d = 3'd0;
      end
    end
  end

  // Parser context and output registers.
  always_ff @(posedge clk) begin
    if (nreset) begin
      ps_q    <= '0;
      pos_q   <= 3'd0;
      v_q     <= 1'b0;
      start_q <= 1'b0;
      len_q   <= '0;
      mask_q  <= '0;
      data_q  <= '0;
    end else begin
      ps_q    <= ps_d;
      pos_q   <= pos_d;
      v_q     <= v_d;
      start_q <= start_d;
      len_q   <= len_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
    end
  end

  assign mold_msg_v_o     = v_q;
  assign mold_msg_start_o = start_q;
  assign mold_msg_len_o   = len_q;
  assign mold_msg_mask_o  = mask_q;
  assign mold_msg_data_o  = data_q;

endmodule

// File: tb/tb_top.sv
// Bench for the MoldUDP64 splitter: directed packets plus random packets
// checked against a byte-ownership reference model.
module tb_top;

  logic        clk;
  logic        nreset;
  logic        tvalid;
  logic [7:0]  tkeep;
  logic [63:0] tdata;
  logic        tlast;
  logic        tuser;
  logic        tready;
  logic        v_o;
  logic        start_o;
  logic [15:0] len_o;
  logic [7:0]  mask_o;
  logic [63:0] data_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected output record: {start, len[15:0], mask[7:0], data[63:0]}.
  logic [88:0] exp_q[$];
  logic [88:0] pend_q[$];
  int          pend_b[$];
  logic [7:0]  pkt[$];
  logic [63:0] words[64];
  logic [7:0]  keeps[64];
  int          exp_stall[64];
  int          nb;

  top dut (
    .clk               (clk),
    .nreset            (nreset),
    .upd_axis_tvalid_i (tvalid),
    .upd_axis_tkeep_i  (tkeep),
    .upd_axis_tdata_i  (tdata),
    .upd_axis_tlast_i  (tlast),
    .upd_axis_tuser_i  (tuser),
    .upd_axis_tready_o (tready),
    .mold_msg_v_o      (v_o),
    .mold_msg_start_o  (start_o),
    .mold_msg_len_o    (len_o),
    .mold_msg_mask_o   (mask_o),
    .mold_msg_data_o   (data_o)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every output beat must match the head of the expected queue.
  always @(negedge clk) begin
    logic [88:0] e;
    if (v_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_v", 64'(v_o), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("start", 64'(start_o), 64'(e[88]));
        check("len",   64'(len_o),   64'(e[87:72]));
        check("mask",  64'(mask_o),  64'(e[71:64]));
        check("data",  data_o,       e[63:0]);
      end
    end
  end

  // Packet construction helpers
  function automatic void put8(input logic [7:0] b);
    pkt.push_back(b);
  endfunction

  function automatic void put16(input logic [15:0] v);
    pkt.push_back(v[7:0]);
    pkt.push_back(v[15:8]);
  endfunction

  function automatic void put_hdr(input logic [79:0] sid, input logic [63:0] seq, input logic [15:0] n);
    for (int i = 0; i < 10; i++) pkt.push_back(sid[8*i +: 8]);
    for (int i = 0; i < 8; i++)  pkt.push_back(seq[8*i +: 8]);
    put16(n);
  endfunction

  function automatic void make_beats();
    int idx;
    nb = (pkt.size() + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      keeps[b] = 8'h00;
      for (int k = 0; k < 8; k++) begin
        idx = 8 * b + k;
        if (idx < pkt.size()) begin
          words[b][8*k +: 8] = pkt[idx];
          keeps[b][k] = 1'b1;
        end else begin
          words[b][8*k +: 8] = 8'($urandom);
        end
      end
    end
  endfunction

  function automatic void clear_pend();
    pend_q.delete();
    pend_b.delete();
    for (int b = 0; b < 64; b++) exp_stall[b] = 0;
  endfunction

  function automatic void push_exp(input int b, input logic st, input logic [15:0] len, input logic [7:0] mask);
    pend_q.push_back({st, len, mask, words[b]});
    pend_b.push_back(b);
  endfunction

  // Reference model: assign each stream byte to the message owning it, then
  // cut every beat into runs of same-owner bytes; one run is one output.
  function automatic void model();
    int total, pos, n, len, prev, nseg, idx;
    int owner[];
    bit first_a[];
    int mlen[];
    logic [88:0] seg;
    bit have;
    clear_pend();
    total = pkt.size();
    owner = new[total];
    first_a = new[total];
    mlen = new[total];
    for (int i = 0; i < total; i++) begin
      owner[i] = -1;
      first_a[i] = 1'b0;
      mlen[i] = 0;
    end
    if (total >= 20) begin
      n = int'({pkt[19], pkt[18]});
      pos = 20;
      for (int m = 0; m < n && pos + 2 <= total; m++) begin
        len = int'({pkt[pos+1], pkt[pos]});
        pos += 2;
        for (int i = 0; i < len && pos < total; i++) begin
          owner[pos] = m;
          first_a[pos] = (i == 0);
          mlen[pos] = len;
          pos++;
        end
      end
    end
    for (int b = 0; b < nb; b++) begin
      prev = -1;
      nseg = 0;
      have = 1'b0;
      seg = '0;
      for (int k = 0; k < 8; k++) begin
        idx = 8 * b + k;
        if (idx < total && owner[idx] >= 0) begin
          if (owner[idx] != prev) begin
            if (have) begin
              pend_q.push_back(seg);
              pend_b.push_back(b);
            end
            seg = {first_a[idx], 16'(mlen[idx]), 8'h00, words[b]};
            have = 1'b1;
            nseg++;
            prev = owner[idx];
          end
          seg[64+k] = 1'b1;
        end
      end
      if (have) begin
        pend_q.push_back(seg);
        pend_b.push_back(b);
      end
      exp_stall[b] = (nseg > 0) ? nseg - 1 : 0;
    end
  endfunction

  // Directed packets
  function automatic void build_basic();
    pkt.delete();
    put_hdr(80'hDEADBEEF, 64'hF0F0F0F0F0F0F0F0, 16'd2);
    put16(16'h0010);
    repeat (2) put8(8'hFF);
    repeat (8) put8(8'hAA);
    repeat (6) put8(8'hBB);
    put16(16'h0008);
    repeat (8) put8(8'hDD);
    make_beats();
    clear_pend();
    push_exp(2, 1'b1, 16'd16, 8'hC0);
    push_exp(3, 1'b0, 16'd16, 8'hFF);
    push_exp(4, 1'b0, 16'd16, 8'h3F);
    push_exp(5, 1'b1, 16'd8,  8'hFF);
  endfunction

  function automatic void build_two_in_beat();
    pkt.delete();
    put_hdr({16'h1234, $urandom, $urandom}, {$urandom, $urandom}, 16'd3);
    put16(16'd2); put8(8'h11); put8(8'h22);
    put16(16'd1); put8(8'h33);
    put16(16'd1); put8(8'h44);
    make_beats();
    clear_pend();
    push_exp(2, 1'b1, 16'd2, 8'hC0);
    push_exp(3, 1'b1, 16'd1, 8'h04);
    push_exp(3, 1'b1, 16'd1, 8'h20);
    exp_stall[3] = 1;
  endfunction

  function automatic void build_empty();
    pkt.delete();
    put_hdr({16'h0, $urandom, $urandom}, {$urandom, $urandom}, 16'd0);
    repeat (12) put8(8'($urandom));
    make_beats();
    clear_pend();
  endfunction

  // Driver tasks
  task automatic do_reset(input int b);
    @(negedge clk);
    #1;
    nreset = 1'b1;
    tvalid = 1'b1;
    tdata  = words[b];
    tkeep  = keeps[b];
    tlast  = 1'b0;
    tuser  = 1'b0;
    @(negedge clk);
    check("rst_mid_tready", 64'(tready), 64'd0);
    check("rst_mid_v",      64'(v_o),    64'd0);
    check("rst_mid_mask",   64'(mask_o), 64'd0);
    check("rst_mid_data",   data_o,      64'd0);
    @(posedge clk);
    #1;
    nreset = 1'b0;
    tvalid = 1'b0;
    check("rst_mid_pending", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic send_pkt(input int user_beat, input int rst_beat, input int gap_max);
    int stalls;
    int want;
    logic rdy;
    logic [88:0] e;
    for (int b = 0; b < nb; b++) begin
      if (b == rst_beat) begin
        do_reset(b);
        clear_pend();
        return;
      end
      while (pend_b.size() > 0 && pend_b[0] == b) begin
        e = pend_q.pop_front();
        void'(pend_b.pop_front());
        if (user_beat < 0 || b < user_beat) exp_q.push_back(e);
      end
      tvalid = 1'b1;
      tdata  = words[b];
      tkeep  = keeps[b];
      tlast  = (b == nb - 1);
      tuser  = (b == user_beat);
      stalls = 0;
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        rdy = tready;
        @(posedge clk);
        #1;
        if (rdy) break;
        stalls++;
      end
      want = (user_beat >= 0 && b >= user_beat) ? 0 : exp_stall[b];
      check("stall_cycles", 64'(stalls), 64'(want));
      tvalid = 1'b0;
      tlast  = 1'b0;
      tuser  = 1'b0;
      repeat ($urandom_range(gap_max, 0)) begin
        @(posedge clk);
        #1;
      end
    end
    clear_pend();
    repeat (3) @(posedge clk);
    #1;
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // Main sequence
  initial begin
    int n;
    int len;
    int cut;
    int user;
    nreset = 1'b1;
    tvalid = 1'b0;
    tkeep  = 8'h00;
    tdata  = 64'h0;
    tlast  = 1'b0;
    tuser  = 1'b0;
    repeat (3) @(posedge clk);
    tvalid = 1'b1;
    tkeep  = 8'hFF;
    @(negedge clk);
    check("rst_v",      64'(v_o),     64'd0);
    check("rst_start",  64'(start_o), 64'd0);
    check("rst_len",    64'(len_o),   64'd0);
    check("rst_mask",   64'(mask_o),  64'd0);
    check("rst_data",   data_o,       64'd0);
    check("rst_tready", 64'(tready),  64'd0);
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    nreset = 1'b0;
    @(posedge clk);
    #1;

    build_basic();        send_pkt(-1, -1, 0);
    build_two_in_beat();  send_pkt(-1, -1, 1);
    build_empty();        send_pkt(-1, -1, 0);
    build_basic();        send_pkt(3, -1, 0);
    build_basic();        send_pkt(-1, -1, 0);
    build_basic();        send_pkt(-1, 4, 0);
    build_basic();        send_pkt(-1, -1, 0);

    // Maximum length message, cut short by tlast.
    pkt.delete();
    put_hdr({16'h0, $urandom, $urandom}, {$urandom, $urandom}, 16'd1);
    put16(16'hFFFF);
    repeat (64) put8(8'($urandom));
    make_beats();
    model();
    send_pkt(-1, -1, 1);

    for (int t = 0; t < 40; t++) begin
      pkt.delete();
      n = $urandom_range(4, 0);
      put_hdr({16'($urandom), $urandom, $urandom}, {$urandom, $urandom}, 16'(n));
      for (int m = 0; m < n; m++) begin
        len = ($urandom_range(1, 0) == 0) ? $urandom_range(3, 0) : $urandom_range(24, 0);
        put16(16'(len));
        for (int i = 0; i < len; i++) put8(8'($urandom));
      end
      repeat ($urandom_range(6, 0)) put8(8'($urandom));
      if ($urandom_range(3, 0) == 0) begin
        cut = $urandom_range(pkt.size(), 1);
        while (pkt.size() > cut) void'(pkt.pop_back());
      end
      make_beats();
      model();
      user = ($urandom_range(5, 0) == 0) ? int'($urandom_range(nb - 1, 0)) : -1;
      send_pkt(user, -1, 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameter AXI_DATA_W, default 64: stream data width in bits; only 64 is supported.
REQ-002 Parameter AXI_KEEP_W, default AXI_DATA_W/8: byte-lane count.
REQ-003 Parameter ML_W, default 16: MoldUDP64 message-length field width.
REQ-004 clk  in  1  single clock; all logic is rising-edge.
REQ-005 nreset  in  1  reset, synchronous and active-high.
REQ-006 upd_axis_tvalid_i/tkeep_i/tdata_i/tlast_i/tuser_i  in  1/8/64/1/1  UDP payload AXI-stream; tuser = packet error.
REQ-007 upd_axis_tready_o  out  1  stream ready.
REQ-008 mold_msg_v_o  out  1  message data beat valid.
REQ-009 mold_msg_start_o  out  1  first beat of a message.
REQ-010 mold_msg_len_o  out  16  length of the current message.
REQ-011 mold_msg_mask_o  out  8  lanes of mold_msg_data_o belonging to the message.
REQ-012 mold_msg_data_o  out  64  message payload data, input lane positions kept.

Function
REQ-013 A beat is accepted when tvalid=1 and tready=1; byte lane k = tdata[8k+7:8k]; earlier stream bytes are on lower lanes.
REQ-014 Multi-byte fields are read with no byte swap: the lower lane is the LSB.
REQ-015 Packet bytes 0-9 = session id, 10-17 = sequence number, 18-19 = message count (N); header spans beats 0-2, lanes 0-3 of beat 2.
REQ-016 Each message is a 2-byte length L followed by L payload bytes, back to back; length fields may straddle a beat boundary.
REQ-017 FSM states: HDR (count header bytes), LEN (collect length bytes), PAYLOAD (count down L), DRAIN (discard until tlast).
REQ-018 HDR goes to LEN after 20 bytes if N>0, else to DRAIN.
REQ-019 LEN goes to PAYLOAD after 2 bytes, or to LEN of the next message if L=0 (no output is produced).
REQ-020 PAYLOAD goes to LEN when L bytes are consumed, or to DRAIN once N messages are done.
REQ-021 An accepted beat with tlast=1 returns the FSM to HDR at the next packet regardless of state.
REQ-022 Output is registered with 1-cycle latency: v=1 the cycle after a beat that carries payload bytes of the current message.
REQ-023 On a valid output beat, data = that input beat, mask = its payload lanes, start=1 on the message's first payload beat, len = L throughout the message.
REQ-024 Only lanes with tkeep=1 count as bytes; the tlast beat may be partial.
REQ-025 If one beat holds payload segments of two or more messages, emit one segment per cycle, drop tready for the extra cycles and re-present the same beat.
REQ-026 Otherwise tready=1.
REQ-027 tuser=1 on any accepted beat forces DRAIN, suppresses outputs for the rest of that packet, and never emits v for that beat.
REQ-028 tlast arriving before N messages complete truncates silently: the last partial message is emitted as far as received.
REQ-029 Counters are 16-bit; L=65535 must not wrap.

Reset
REQ-030 While nreset=1, state becomes HDR with counters cleared, v=0, start=0, len=0, mask=0, data=0 and tready=0.
REQ-031 Reset asserted mid-packet discards the packet; after release, the next accepted beat is treated as header beat 0.

Structure
REQ-032 A shared package holds the widths (64/8/16), field offsets (10, 8, 2, header 20) and the FSM state enum.
REQ-033 One sub-module, mold_len_cnt, tracks the byte position and the remaining-length count per beat and produces the lane masks.

Verification
REQ-034 Header sid=0xDEADBEEF, seq=0xF0F0F0F0F0F0F0F0, N=2; beat2 = {FFFF,0010,hdr}; beat3 = AA..; beat4 = {0008,BB..}; beat5 = DD.. with tlast. Required: v after beat2 with start=1, len=16, mask=0xC0; after beat3 mask=0xFF; after beat4 mask=0x3F; after beat5 start=1, len=8, mask=0xFF.
REQ-035 N=0 packet -> no v, tready stays 1.
REQ-036 Two 1-byte messages in one beat -> tready low 1 cycle, two outputs each with start=1 and len=1, masks on distinct lanes.
REQ-037 tuser=1 on beat 3 of the REQ-034 packet -> only the beat-2 output appears; the next packet parses correctly.
REQ-038 nreset pulse mid-payload -> outputs go to 0; a following clean packet produces the REQ-034 responses.
